timer_counter: RTL and testbench

- 8-bit timer count stage directly downstream of the prescaler/clock-select stage; consumes its divided clock `clk_in` (pclk/2, /4, /8 or /16).
- `clk_in` is not used as a clock. It is sampled in the pclk domain and edge-detected into a single-cycle count tick.
- Supports up/down counting, parallel load from the data register, and sticky overflow/underflow flags plus one-cycle pulses for the status/interrupt logic.

---
 rtl/timer_counter.sv | 133 +++++++++++++
 tb/tb_timer_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
//
// Purpose:
//   8-bit (WIDTH) timer count stage fed by the prescaler/clock-select stage.
//   The divided clock clk_in is never used as a clock. It is sampled in the
//   pclk domain and rising-edge detected into a single-cycle count tick.
//   Supported operations:
//     - up/down counting
//     - parallel load from the timer data register
//     - sticky overflow/underflow flags, plus one-cycle wrap pulses
//
// Optional feature (macro TIMER_COMPARE_EN):
//   Adds the input cmp and the output cmp_match. cmp_match is a registered
//   one-cycle pulse that fires when a tick update lands the count on cmp.
//   Reaching the same value by a load does not fire it.
//
// Ports:
//   pclk       in   system clock, the only clock in the block
//   presetn    in   asynchronous active-low reset
//   clk_in     in   divided clock, sampled as data
//   en         in   count enable
//   up_dn      in   direction: 0 = up, 1 = down
//   load       in   copy tdr into the counter (highest priority)
//   tdr        in   load value [WIDTH]
//   clr_ovf    in   clear sticky overflow flag
//   clr_udf    in   clear sticky underflow flag
//   cmp        in   compare value [WIDTH]          (TIMER_COMPARE_EN only)
//   cnt        out  current count [WIDTH]
//   ovf_pulse  out  one-cycle pulse on up-count wrap
//   udf_pulse  out  one-cycle pulse on down-count wrap
//   tmr_ovf    out  sticky overflow flag
//   tmr_udf    out  sticky underflow flag
//   cmp_match  out  one-cycle compare pulse        (TIMER_COMPARE_EN only)
// -----------------------------------------------------------------------------
module timer_counter #(
    parameter int WIDTH = 8
) (
    input  logic             pclk,
    input  logic             presetn,
    input  logic             clk_in,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] tdr,
    input  logic             clr_ovf,
    input  logic             clr_udf,
`ifdef TIMER_COMPARE_EN
    input  logic [WIDTH-1:0] cmp,
    output logic             cmp_match,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             ovf_pulse,
    output logic             udf_pulse,
    output logic             tmr_ovf,
    output logic             tmr_udf
);

    logic             clk_in_q;
    logic [WIDTH-1:0] cnt_q,     cnt_d;
    logic             ovf_pls_q, ovf_pls_d;
    logic             udf_pls_q, udf_pls_d;
    logic             tmr_ovf_q, tmr_ovf_d;
    logic             tmr_udf_q, tmr_udf_d;
    logic             tick;

    // clk_in_q follows clk_in even while disabled.
    // Enabling while clk_in is already high therefore cannot fake an edge.
    assign tick = en & clk_in & ~clk_in_q;

    always_comb begin
        cnt_d     = cnt_q;
        ovf_pls_d = 1'b0;
        udf_pls_d = 1'b0;
        if (load) begin
            // A coincident tick is dropped on purpose.
            cnt_d = tdr;
        end else if (tick) begin
            if (!up_dn) begin
                cnt_d     = cnt_q + 1'b1;
                ovf_pls_d = &cnt_q;
            end else begin
                cnt_d     = cnt_q - 1'b1;
                udf_pls_d = ~|cnt_q;
            end
        end
        // The registered pulse sets the flag, and set beats clear.
        tmr_ovf_d = ovf_pls_q | (tmr_ovf_q & ~clr_ovf);
        tmr_udf_d = udf_pls_q | (tmr_udf_q & ~clr_udf);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            clk_in_q  <= 1'b0;
            cnt_q     <= '0;
            ovf_pls_q <= 1'b0;
            udf_pls_q <= 1'b0;
            tmr_ovf_q <= 1'b0;
            tmr_udf_q <= 1'b0;
        end else begin
            clk_in_q  <= clk_in;
            cnt_q     <= cnt_d;
            ovf_pls_q <= ovf_pls_d;
            udf_pls_q <= udf_pls_d;
            tmr_ovf_q <= tmr_ovf_d;
            tmr_udf_q <= tmr_udf_d;
        end
    end

    assign cnt       = cnt_q;
    assign ovf_pulse = ovf_pls_q;
    assign udf_pulse = udf_pls_q;
    assign tmr_ovf   = tmr_ovf_q;
    assign tmr_udf   = tmr_udf_q;

`ifdef TIMER_COMPARE_EN
    logic cmp_match_q, cmp_match_d;

    // Only a tick update can produce a match. A load never does.
    assign cmp_match_d = tick & ~load & (cnt_d == cmp);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cmp_match_q <= 1'b0;
        end else begin
            cmp_match_q <= cmp_match_d;
        end
    end

    assign cmp_match = cmp_match_q;
`endif

endmodule

// File: tb/tb_timer_counter.sv
// -----------------------------------------------------------------------------
// tb_timer_counter
//
// Directed bench for timer_counter.
//   - A vector table covers wrap, flags, direction and load priority.
//   - Hand-written sequences cover reset, enable gating, reset during a count
//     and (with TIMER_COMPARE_EN) the compare pulse.
//
// Timing of inputs and checks:
//   - Inputs are driven 1 time unit after a pclk rising edge.
//   - Outputs are checked 1 time unit after the following rising edge.
//   - clk_in is driven directly by the bench to model the prescaler output.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_counter;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       clk_in, en, up_dn, load, clr_ovf, clr_udf;
    logic [7:0] tdr;
    logic [7:0] cnt;
    logic       ovf_pulse, udf_pulse, tmr_ovf, tmr_udf;
`ifdef TIMER_COMPARE_EN
    logic [7:0] cmp;
    logic       cmp_match;
`endif

    int tests = 0;
    int fails = 0;

    always #5 pclk = ~pclk;

    timer_counter #(.WIDTH(8)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .clk_in    (clk_in),
        .en        (en),
        .up_dn     (up_dn),
        .load      (load),
        .tdr       (tdr),
        .clr_ovf   (clr_ovf),
        .clr_udf   (clr_udf),
`ifdef TIMER_COMPARE_EN
        .cmp       (cmp),
        .cmp_match (cmp_match),
`endif
        .cnt       (cnt),
        .ovf_pulse (ovf_pulse),
        .udf_pulse (udf_pulse),
        .tmr_ovf   (tmr_ovf),
        .tmr_udf   (tmr_udf)
    );

    typedef struct {
        logic       ld;
        logic [7:0] tdr;
        logic       up;
        logic       ci;
        logic       co;
        logic       cu;
        logic [7:0] ecnt;
        logic       eop;
        logic       eup;
        logic       eov;
        logic       eun;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one pclk edge with the given clk_in level, then land 1 unit after it.
    task automatic step(input logic ci);
        clk_in = ci;
        @(posedge pclk);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [7:0] ecnt,
                           input logic eop, input logic eup, input logic eov, input logic eun);
        chk({name, ".cnt"}, {24'h0, cnt}, {24'h0, ecnt});
        chk({name, ".ovf_pulse"}, {31'h0, ovf_pulse}, {31'h0, eop});
        chk({name, ".udf_pulse"}, {31'h0, udf_pulse}, {31'h0, eup});
        chk({name, ".tmr_ovf"}, {31'h0, tmr_ovf}, {31'h0, eov});
        chk({name, ".tmr_udf"}, {31'h0, tmr_udf}, {31'h0, eun});
    endtask

    initial begin
        // Fields: ld, tdr, up, ci, co, cu | cnt, ovf_p, udf_p, tmr_ovf, tmr_udf.
        // Up overflow: FD -> FE -> FF -> 00 (pulse), then the sticky flag.
        tbl[0]  = '{1'b1, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        // Down underflow: 01 -> 00 -> FF (pulse). Set and clear together keeps the flag.
        tbl[9]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
        // Load priority: a load coincident with a tick wins, then counting resumes.
        tbl[17] = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h56, 1'b0, 1'b0, 1'b0, 1'b0};

        presetn = 1'b0; clk_in = 1'b0; en = 1'b1; up_dn = 1'b0; load = 1'b0;
        tdr = 8'h00; clr_ovf = 1'b0; clr_udf = 1'b0;
`ifdef TIMER_COMPARE_EN
        cmp = 8'h05;
`endif

        // Reset held with clk_in toggling and en=1.
        for (int i = 0; i < 6; i++) step(i[0]);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef TIMER_COMPARE_EN
        chk("reset.cmp_match", {31'h0, cmp_match}, 32'h0);
`endif

        // Release, then run clk_in at pclk/2 and count up from 0.
        clk_in = 1'b0;
        presetn = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step(i[0] == 1'b0);
            chk($sformatf("count2[%0d]", i), {24'h0, cnt}, (i / 2) + 1);
`ifdef TIMER_COMPARE_EN
            chk($sformatf("cmp_match[%0d]", i), {31'h0, cmp_match},
                {31'h0, (i[0] == 1'b0) && ((i / 2) + 1 == 5)});
`endif
        end
        $display("[TB] post-reset count reached %0h", cnt);

`ifdef TIMER_COMPARE_EN
        // Reaching cmp through a load must not pulse.
        load = 1'b1; tdr = 8'h05;
        step(1'b0);
        load = 1'b0;
        chk("cmp_load.cnt", {24'h0, cnt}, 32'h05);
        chk("cmp_load.cmp_match", {31'h0, cmp_match}, 32'h0);
`endif

        // Table-driven vectors.
        for (int v = 0; v < 21; v++) begin
            load = tbl[v].ld; tdr = tbl[v].tdr; up_dn = tbl[v].up;
            clr_ovf = tbl[v].co; clr_udf = tbl[v].cu;
            step(tbl[v].ci);
            chk_all($sformatf("vec%0d", v), tbl[v].ecnt, tbl[v].eop, tbl[v].eup, tbl[v].eov, tbl[v].eun);
            $display("[TB] vec%0d cnt=%0h ovf_p=%0b udf_p=%0b ovf=%0b udf=%0b",
                     v, cnt, ovf_pulse, udf_pulse, tmr_ovf, tmr_udf);
        end
        load = 1'b0; clr_ovf = 1'b0; clr_udf = 1'b0; up_dn = 1'b0;

        // Enable gating: 10 clk_in periods while disabled, with the count frozen.
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(i[0]);
            chk($sformatf("gate[%0d]", i), {24'h0, cnt}, 32'h56);
        end
        // Re-enable while clk_in is high: no tick until the next rise.
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            chk($sformatf("reen_hi[%0d]", i), {24'h0, cnt}, 32'h56);
        end
        step(1'b0);
        chk("reen_lo", {24'h0, cnt}, 32'h56);
        step(1'b1);
        chk("reen_rise", {24'h0, cnt}, 32'h57);
        $display("[TB] gating done cnt=%0h", cnt);

        // Reset during a count: the return to reset values is immediate and asynchronous.
        #2;
        presetn = 1'b0;
        #1;
        chk("midrst.async", {24'h0, cnt}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(i[0] == 1'b0);
            chk($sformatf("midrst[%0d]", i), {24'h0, cnt}, 32'h0);
        end
        clk_in = 1'b0;
        presetn = 1'b1;
        step(1'b0);
        chk("midrst.hold", {24'h0, cnt}, 32'h0);
        step(1'b1);
        chk("midrst.first", {24'h0, cnt}, 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
